// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the DM port arbiter.
// Optional feature macro: DM_ARB_RR_EN (round-robin arbitration).
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dm_arb_state_e;

  localparam int unsigned DEF_MEM_BYTES = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Requester and data-memory signal bundle for the DM port arbiter.
// Optional feature macro: DM_ARB_RR_EN (handled in dm_arb_pick).
interface dm_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic          err0;
  logic          err1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          owner;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWriteData;
  logic          MemWrite;
  logic [DW-1:0] MemReadData;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  MemReadData,
    output ack0, ack1, err0, err1,
    output rdata0, rdata1, owner,
    output MemAddr, MemWriteData, MemWrite
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output MemReadData,
    input  ack0, ack1, err0, err1,
    input  rdata0, rdata1, owner,
    input  MemAddr, MemWriteData, MemWrite
  );

endinterface

// File: rtl/dm_arb_pick.sv
// Combinational winner selector for the two DM requesters.
// Optional feature macro: DM_ARB_RR_EN (round-robin instead of fixed priority).
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic owner_i,
  output logic win_o
);

  // With no request the choice is unused; holding owner keeps it stable.
`ifdef DM_ARB_RR_EN
  always_comb begin
    win_o = owner_i;
    if (req0_i && req1_i)
      win_o = ~owner_i;
    else if (req0_i)
      win_o = PORT_CPU;
    else if (req1_i)
      win_o = PORT_AUX;
  end
`else
  always_comb begin
    win_o = owner_i;
    if (req0_i)
      win_o = PORT_CPU;
    else if (req1_i)
      win_o = PORT_AUX;
  end
`endif

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter and IDLE/ACCESS/RESP sequencer for the big-endian DM.
// Optional feature macro: DM_ARB_RR_EN (round-robin arbitration).
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  dm_port_arbiter_if.slave  bus
);

  localparam logic [AW-1:0] LAST_WORD = AW'(MEM_BYTES - 4);

  dm_arb_state_e state_q, state_d;
  logic          owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          win;
  logic          any_req;
  logic          in_rng;

  assign any_req = bus.req0 | bus.req1;
  // Compare the base address only so addr+3 can never wrap.
  assign in_rng  = (addr_q <= LAST_WORD);

  dm_arb_pick u_pick (
    .req0_i  (bus.req0),
    .req1_i  (bus.req1),
    .owner_i (owner_q),
    .win_o   (win)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state and DM/ack outputs, all decoded from the current state.
  always_comb begin
    state_d          = state_q;
    bus.MemAddr      = '0;
    bus.MemWriteData = '0;
    bus.MemWrite     = 1'b0;
    bus.ack0         = 1'b0;
    bus.ack1         = 1'b0;
    bus.err0         = 1'b0;
    bus.err1         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req)
          state_d = ACCESS;
      end
      ACCESS: begin
        state_d          = RESP;
        bus.MemWriteData = wdata_q;
        if (in_rng) begin
          bus.MemAddr  = addr_q;
          bus.MemWrite = we_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (owner_q == PORT_AUX) begin
          bus.ack1 = 1'b1;
          bus.err1 = ~in_rng;
        end else begin
          bus.ack0 = 1'b1;
          bus.err0 = ~in_rng;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning request at the IDLE sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= PORT_AUX;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && any_req) begin
      owner_q <= win;
      if (win == PORT_AUX) begin
        we_q    <= bus.we1;
        addr_q  <= bus.addr1;
        wdata_q <= bus.wdata1;
      end else begin
        we_q    <= bus.we0;
        addr_q  <= bus.addr0;
        wdata_q <= bus.wdata0;
      end
    end
  end

  // Capture load data at the end of ACCESS; out-of-range loads return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == ACCESS && !we_q) begin
      if (owner_q == PORT_AUX)
        rdata1_q <= in_rng ? bus.MemReadData : '0;
      else
        rdata0_q <= in_rng ? bus.MemReadData : '0;
    end
  end

  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  assign bus.owner  = owner_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter with a byte-wide DM model.
// Expectations follow DM_ARB_RR_EN when the bench is built with it.
module tb_dm_port_arbiter;
  import dm_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   n_wr;
  int   n_ack0;
  int   n_ack1;
  logic [7:0] mem [0:7];

  dm_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  dm_port_arbiter #(.MEM_BYTES(8), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.MemReadData = 32'h0;
    if (bus.MemAddr <= 32'd4)
      bus.MemReadData = {mem[bus.MemAddr[2:0]],
                         mem[bus.MemAddr[2:0] + 3'd1],
                         mem[bus.MemAddr[2:0] + 3'd2],
                         mem[bus.MemAddr[2:0] + 3'd3]};
  end

  always @(negedge clk) begin
    if (bus.MemWrite) begin
      n_wr <= n_wr + 1;
      if (bus.MemAddr <= 32'd4) begin
        mem[bus.MemAddr[2:0]]        <= bus.MemWriteData[31:24];
        mem[bus.MemAddr[2:0] + 3'd1] <= bus.MemWriteData[23:16];
        mem[bus.MemAddr[2:0] + 3'd2] <= bus.MemWriteData[15:8];
        mem[bus.MemAddr[2:0] + 3'd3] <= bus.MemWriteData[7:0];
      end
    end
    if (bus.ack0) n_ack0 <= n_ack0 + 1;
    if (bus.ack1) n_ack1 <= n_ack1 + 1;
  end

  function automatic logic [31:0] mword(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0, a0, a1;
    logic [0:0] expw;
    total = 0; bad = 0;
    n_wr = 0; n_ack0 = 0; n_ack1 = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_owner", 32'(bus.owner), 32'd1);
    chk("rst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    chk("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("rst_memaddr", bus.MemAddr, 32'd0);
    chk("rst_memwdata", bus.MemWriteData, 32'd0);
    chk("rst_rdata", bus.rdata0 | bus.rdata1, 32'd0);

    // Port 0 store to addr 4
    step();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4; bus.wdata0 = 32'hDEADBEEF;
    step();
    bus.req0 = 0;
    chk("st_memwrite", 32'(bus.MemWrite), 32'd1);
    chk("st_memaddr", bus.MemAddr, 32'd4);
    chk("st_wdata", bus.MemWriteData, 32'hDEADBEEF);
    chk("st_owner", 32'(bus.owner), 32'd0);
    chk("st_ack_early", 32'(bus.ack0), 32'd0);
    step();
    chk("st_ack0", 32'(bus.ack0), 32'd1);
    chk("st_err0", 32'(bus.err0), 32'd0);
    chk("st_memwrite_off", 32'(bus.MemWrite), 32'd0);
    chk("st_mem", mword(4), 32'hDEADBEEF);
    chk("st_wr_count", 32'(n_wr), 32'd1);
    step();
    chk("st_ack_done", 32'(bus.ack0), 32'd0);

    // Port 1 load from addr 4
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4;
    step();
    bus.req1 = 0;
    chk("ld1_owner", 32'(bus.owner), 32'd1);
    chk("ld1_memwrite", 32'(bus.MemWrite), 32'd0);
    step();
    chk("ld1_ack1", 32'(bus.ack1), 32'd1);
    chk("ld1_ack0", 32'(bus.ack0), 32'd0);
    chk("ld1_err1", 32'(bus.err1), 32'd0);
    chk("ld1_rdata1", bus.rdata1, 32'hDEADBEEF);
    step();

    // Port 0 in-range load, so the later out-of-range load visibly zeroes rdata0
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4;
    step();
    bus.req0 = 0;
    step();
    chk("ld0_ack0", 32'(bus.ack0), 32'd1);
    chk("ld0_rdata0", bus.rdata0, 32'hDEADBEEF);
    step();

    // Out-of-range store at addr 5
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5; bus.wdata0 = 32'h12345678;
    step();
    bus.req0 = 0;
    chk("oor_st_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("oor_st_memaddr", bus.MemAddr, 32'd0);
    step();
    chk("oor_st_ack0", 32'(bus.ack0), 32'd1);
    chk("oor_st_err0", 32'(bus.err0), 32'd1);
    step();

    // Out-of-range load at the top of the address space
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'hFFFFFFFF;
    step();
    bus.req0 = 0;
    chk("oor_ld_memaddr", bus.MemAddr, 32'd0);
    step();
    chk("oor_ld_ack0", 32'(bus.ack0), 32'd1);
    chk("oor_ld_err0", 32'(bus.err0), 32'd1);
    chk("oor_ld_rdata0", bus.rdata0, 32'd0);
    chk("oor_wr_count", 32'(n_wr), 32'd1);
    chk("oor_mem", mword(4), 32'hDEADBEEF);
    step();

    // Contention from reset (owner = 1)
    @(posedge clk); #2 rst_n = 0; #4 rst_n = 1;
    step();
    bus.we0 = 0; bus.addr0 = 4; bus.we1 = 0; bus.addr1 = 0;
    bus.req0 = 1; bus.req1 = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef DM_ARB_RR_EN
      expw = 1'(i);
`else
      expw = 1'b0;
`endif
      step();
      chk($sformatf("arb_owner%0d", i), 32'(bus.owner), 32'(expw));
      step();
      chk($sformatf("arb_ack0_%0d", i), 32'(bus.ack0), 32'(!expw));
      chk($sformatf("arb_ack1_%0d", i), 32'(bus.ack1), 32'(expw));
      if (expw) bus.req1 = 0; else bus.req0 = 0;
      step();
      bus.req0 = 1; bus.req1 = 1;
    end
    bus.req0 = 0; bus.req1 = 0;
    step();

    // Reset in the middle of a store ACCESS
    a0 = n_ack0;
    w0 = n_wr;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 0; bus.wdata0 = 32'h11223344;
    step();
    chk("rst_acc_memwrite_pre", 32'(bus.MemWrite), 32'd1);
    #1 rst_n = 0;
    #1;
    chk("rst_acc_memwrite", 32'(bus.MemWrite), 32'd0);
    bus.req0 = 0;
    step();
    #2 rst_n = 1;
    step();
    step();
    chk("rst_acc_mem", mword(0), 32'h00000000);
    chk("rst_acc_wr", 32'(n_wr - w0), 32'd0);
    chk("rst_acc_noack", 32'(n_ack0 - a0), 32'd0);
    chk("rst_acc_state", 32'(dut.state_q), 32'(IDLE));

    // Single request held high for 10 cycles
    a1 = n_ack1;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4;
    for (int i = 0; i < 10; i++) step();
    bus.req1 = 0;
    chk("hold_acks", 32'(n_ack1 - a1), 32'd3);
    chk("hold_state", 32'(dut.state_q), 32'(ACCESS));
    step();
    chk("hold_last_ack", 32'(bus.ack1), 32'd1);
    step();
    step();
    chk("hold_idle", 32'(dut.state_q), 32'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
